pipeline_ctrl_gen: RTL and testbench

- Parametrised successor to the fixed 6-stage stall/flush controller.
- Sits beside the pipeline; takes per-stage stall requests, a global stall and the exception type.
- Drives per-stage stall and bubble vectors plus a registered flush/redirect.
- Adds features the previous generation lacked: multi-cycle flush, an exception held across a global stall, and bubble-insert signals.

---
 rtl/pipeline_ctrl_gen.sv | 167 ++++++++++++++++
 tb/tb_pipeline_ctrl_gen.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/pipeline_ctrl_gen.sv
// Pipeline stall/flush controller: per-stage stall and bubble vectors, registered flush/redirect.
// Optional stall watchdog is enabled by defining STALL_WATCHDOG_EN.
module pipeline_ctrl_gen #(
   parameter int                NUM_STAGES   = 6,
   parameter int                ADDR_W       = 32,
   parameter int                EXC_W        = 32,
   parameter logic [EXC_W-1:0]  EXC_NULL     = '0,
   parameter logic [EXC_W-1:0]  EXC_ERET     = 32'h0e,
   parameter logic [ADDR_W-1:0] EXC_VECTOR   = 32'hbfc00380,
   parameter logic [ADDR_W-1:0] INIT_PC      = 32'hbfc00000,
   parameter int                FLUSH_CYCLES = 1,
   parameter int                WDT_LIMIT    = 1024
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [NUM_STAGES-1:0] stall_req,
   input  logic                  stall_all,
   input  logic [ADDR_W-1:0]     cp0_epc,
   input  logic [EXC_W-1:0]      exception_type,
   output logic [NUM_STAGES-1:0] stall,
   output logic [NUM_STAGES-1:0] bubble,
   output logic                  flush,
   output logic [ADDR_W-1:0]     exc_pc,
   output logic                  busy,
   output logic                  wdt_timeout
);

   typedef enum logic [1:0] {IDLE, PEND, FLUSH} state_t;

   localparam logic [3:0] FLUSH_LEN = 4'(FLUSH_CYCLES);

   state_t            state_q, state_d;
   logic              flush_q, flush_d;
   logic              busy_q, busy_d;
   logic [ADDR_W-1:0] exc_pc_q, exc_pc_d;
   logic [ADDR_W-1:0] target_q, target_d;
   logic [3:0]        cnt_q, cnt_d;

   // The oldest stalled stage freezes everything behind it; the stage after it gets a NOP.
   always_comb begin
      int  top;
      logic found;
      stall  = '0;
      bubble = '0;
      top    = 0;
      found  = 1'b0;
      if (stall_all) begin
         stall = '1;
      end else if (state_q != FLUSH) begin
         for (int k = 0; k < NUM_STAGES; k++) begin
            if (stall_req[k]) begin
               top   = k;
               found = 1'b1;
            end
         end
         for (int j = 0; j < NUM_STAGES; j++) begin
            stall[j]  = found && (j <= top);
            bubble[j] = found && (j == top + 1);
         end
      end
   end

   always_comb begin
      state_d  = state_q;
      flush_d  = flush_q;
      exc_pc_d = exc_pc_q;
      target_d = target_q;
      cnt_d    = cnt_q;
      unique case (state_q)
         IDLE: begin
            if (exception_type != EXC_NULL) begin
               target_d = (exception_type == EXC_ERET) ? cp0_epc : EXC_VECTOR;
               if (stall_all) begin
                  state_d = PEND;
               end else begin
                  state_d  = FLUSH;
                  flush_d  = 1'b1;
                  exc_pc_d = target_d;
                  cnt_d    = 4'd1;
               end
            end
         end
         PEND: begin
            if (!stall_all) begin
               state_d  = FLUSH;
               flush_d  = 1'b1;
               exc_pc_d = target_q;
               cnt_d    = 4'd1;
            end
         end
         FLUSH: begin
            // cnt_q counts flush-high cycles already issued; stalled cycles do not count.
            if (cnt_q == FLUSH_LEN) begin
               state_d  = IDLE;
               flush_d  = 1'b0;
               exc_pc_d = INIT_PC;
               cnt_d    = 4'd0;
            end else if (stall_all) begin
               flush_d = 1'b0;
            end else begin
               flush_d = 1'b1;
               cnt_d   = cnt_q + 4'd1;
            end
         end
         default: begin
            state_d  = IDLE;
            flush_d  = 1'b0;
            exc_pc_d = INIT_PC;
            cnt_d    = 4'd0;
         end
      endcase
      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q  <= IDLE;
         flush_q  <= 1'b0;
         busy_q   <= 1'b0;
         exc_pc_q <= INIT_PC;
         target_q <= INIT_PC;
         cnt_q    <= 4'd0;
      end else begin
         state_q  <= state_d;
         flush_q  <= flush_d;
         busy_q   <= busy_d;
         exc_pc_q <= exc_pc_d;
         target_q <= target_d;
         cnt_q    <= cnt_d;
      end
   end

   assign flush  = flush_q;
   assign busy   = busy_q;
   assign exc_pc = exc_pc_q;

`ifdef STALL_WATCHDOG_EN
   localparam int              WDT_W   = $clog2(WDT_LIMIT + 1);
   localparam logic [WDT_W-1:0] WDT_MAX = WDT_W'(WDT_LIMIT);

   logic [WDT_W-1:0] wdt_cnt_q, wdt_cnt_d;
   logic             wdt_q, wdt_d;

   always_comb begin
      wdt_cnt_d = '0;
      if (|stall) begin
         wdt_cnt_d = (wdt_cnt_q == WDT_MAX) ? WDT_MAX : wdt_cnt_q + WDT_W'(1);
      end
      wdt_d = wdt_q | (wdt_cnt_d == WDT_MAX);
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         wdt_cnt_q <= '0;
         wdt_q     <= 1'b0;
      end else begin
         wdt_cnt_q <= wdt_cnt_d;
         wdt_q     <= wdt_d;
      end
   end

   assign wdt_timeout = wdt_q;
`else
   assign wdt_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_pipeline_ctrl_gen.sv
// Self-checking bench for pipeline_ctrl_gen: directed literal checks plus randomized run vs a behavioural model.
module tb_pipeline_ctrl_gen;

   localparam int N   = 6;
   localparam int FC  = 3;
   localparam int WDT = 16;
   localparam logic [31:0] VEC  = 32'hbfc00380;
   localparam logic [31:0] INIT = 32'hbfc00000;
   localparam logic [31:0] ERET = 32'h0e;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic [N-1:0]  stall_req = '0;
   logic          stall_all = 1'b0;
   logic [31:0]   cp0_epc = '0;
   logic [31:0]   exception_type = '0;
   logic [N-1:0]  stall, bubble;
   logic          flush, busy, wdt_timeout;
   logic [31:0]   exc_pc;

   always #5 clk = ~clk;

   pipeline_ctrl_gen #(
      .NUM_STAGES(N), .FLUSH_CYCLES(FC), .WDT_LIMIT(WDT)
   ) dut (
      .clk(clk), .rst(rst), .stall_req(stall_req), .stall_all(stall_all),
      .cp0_epc(cp0_epc), .exception_type(exception_type),
      .stall(stall), .bubble(bubble), .flush(flush), .exc_pc(exc_pc),
      .busy(busy), .wdt_timeout(wdt_timeout)
   );

   int errors = 0;
   int checks = 0;

   // Model: mode 0 = idle, 1 = waiting for stall_all to drop, 2 = flushing; rem = flush cycles still owed
   int          m_mode = 0;
   int          m_rem  = 0;
   logic [31:0] m_tgt  = '0;
   logic [31:0] m_pc   = INIT;
   logic        m_flush = 1'b0;
   logic        m_busy  = 1'b0;
   logic        m_wdt   = 1'b0;
   int          m_wcnt  = 0;
   bit          valid   = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic void model_stall(input logic [N-1:0] req, input logic sa, input int mode,
                                       output logic [N-1:0] s, output logic [N-1:0] b);
      int hi;
      s = '0;
      b = '0;
      hi = -1;
      for (int i = 0; i < N; i++) if (req[i]) hi = i;
      if (sa) s = '1;
      else if (mode != 2 && hi >= 0) begin
         s = N'((64'd1 << (hi + 1)) - 64'd1);
         if (hi + 1 < N) b = N'(64'd1 << (hi + 1));
      end
   endfunction

   task automatic step(input logic rv, input logic [N-1:0] req, input logic sa,
                       input logic [31:0] et, input logic [31:0] epc);
      logic [N-1:0] es, eb;
      logic [31:0]  t;
      rst = rv; stall_req = req; stall_all = sa; exception_type = et; cp0_epc = epc;
      #1;
      model_stall(req, sa, m_mode, es, eb);
      if (valid) begin
         chk("stall", 32'(stall), 32'(es));
         chk("bubble", 32'(bubble), 32'(eb));
      end
      @(posedge clk);
      if (!rv) begin
         m_mode = 0; m_rem = 0; m_pc = INIT; m_flush = 0; m_busy = 0;
         m_wdt = 0; m_wcnt = 0; valid = 1'b1;
      end else begin
`ifdef STALL_WATCHDOG_EN
         m_wcnt = (es != 0) ? ((m_wcnt + 1 > WDT) ? WDT : m_wcnt + 1) : 0;
         if (m_wcnt == WDT) m_wdt = 1'b1;
`endif
         t = (et == ERET) ? epc : VEC;
         if (m_mode == 0 && et != 0) begin
            m_tgt = t;
            if (sa) m_mode = 1;
            else begin m_mode = 2; m_rem = FC - 1; m_flush = 1; m_pc = t; end
         end else if (m_mode == 1 && !sa) begin
            m_mode = 2; m_rem = FC - 1; m_flush = 1; m_pc = m_tgt;
         end else if (m_mode == 2) begin
            if (m_rem == 0) begin m_mode = 0; m_flush = 0; m_pc = INIT; end
            else if (sa) m_flush = 0;
            else begin m_flush = 1; m_rem--; end
         end
         m_busy = (m_mode != 0);
      end
      #1;
      chk("flush", 32'(flush), 32'(m_flush));
      chk("exc_pc", exc_pc, m_pc);
      chk("busy", 32'(busy), 32'(m_busy));
      chk("wdt_timeout", 32'(wdt_timeout), 32'(m_wdt));
   endtask

   initial begin
      int n;
      logic [31:0] et;
      int r;

      step(0, '0, 0, 0, 0);
      step(0, '0, 0, 0, 0);
      step(1, '0, 0, 0, 0);
      chk("rst_exc_pc", exc_pc, 32'hbfc00000);
      chk("rst_flush", 32'(flush), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_stall", 32'(stall), 0);

      step(1, 6'b000100, 0, 0, 0);
      chk("lit_stall_a", 32'(stall), 32'b000111);
      chk("lit_bubble_a", 32'(bubble), 32'b001000);
      step(1, 6'b001010, 0, 0, 0);
      chk("lit_stall_b", 32'(stall), 32'b001111);
      chk("lit_bubble_b", 32'(bubble), 32'b010000);

      step(1, 6'b000100, 0, 32'h01, 0);
      chk("lit_exc_flush", 32'(flush), 1);
      chk("lit_exc_pc", exc_pc, 32'hbfc00380);
      chk("lit_exc_busy", 32'(busy), 1);
      chk("lit_exc_stall", 32'(stall), 0);
      n = 1;
      repeat (4) begin
         step(1, 6'b000100, 0, 0, 0);
         if (flush === 1'b1) n++;
      end
      chk("lit_flush_len", 32'(n), 3);
      chk("lit_pc_back", exc_pc, 32'hbfc00000);

      step(1, '0, 1, ERET, 32'h8000_1234);
      chk("lit_pend_flush", 32'(flush), 0);
      chk("lit_pend_busy", 32'(busy), 1);
      step(1, '0, 1, 32'h01, 32'h1111_0000);
      chk("lit_pend2_flush", 32'(flush), 0);
      chk("lit_pend2_busy", 32'(busy), 1);
      step(1, '0, 0, 0, 0);
      chk("lit_eret_flush", 32'(flush), 1);
      chk("lit_eret_pc", exc_pc, 32'h8000_1234);
      n = 1;
      step(1, '0, 1, 0, 0);
      chk("lit_mid_stall_flush", 32'(flush), 0);
      repeat (4) begin
         step(1, '0, 0, 0, 0);
         if (flush === 1'b1) n++;
      end
      chk("lit_stalled_flush_len", 32'(n), 3);

      step(0, '0, 0, 0, 0);
      repeat (15) step(1, 6'b000001, 0, 0, 0);
      chk("lit_wdt_early", 32'(wdt_timeout), 0);
      step(1, 6'b000001, 0, 0, 0);
`ifdef STALL_WATCHDOG_EN
      chk("lit_wdt_set", 32'(wdt_timeout), 1);
      step(1, '0, 0, 0, 0);
      chk("lit_wdt_sticky", 32'(wdt_timeout), 1);
`else
      chk("lit_wdt_off", 32'(wdt_timeout), 0);
`endif
      step(0, '0, 0, 0, 0);
      chk("lit_wdt_clear", 32'(wdt_timeout), 0);

      for (int i = 0; i < 3000; i++) begin
         r = int'($urandom_range(0, 9));
         if (r < 7) et = 0;
         else if (r == 7) et = 32'h01;
         else if (r == 8) et = ERET;
         else et = $urandom;
         step(($urandom_range(0, 63) != 0),
              ($urandom_range(0, 2) == 0) ? N'($urandom) : '0,
              ($urandom_range(0, 4) == 0), et, $urandom);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
